// File: rtl/tft_arbiter_pkg.sv
// tft_arbiter_pkg: arbiter state encoding, TFT window command bytes and default start timeout
package tft_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, START, DRAW, DRAIN} arb_state_e;
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;
    localparam int START_TIMEOUT_DEF = 16;
    function automatic logic is_window_cmd(input logic [7:0] b);
        return b inside {CMD_CASET, CMD_PASET, CMD_RAMWR};
    endfunction
endpackage

// File: rtl/tft_arbiter_rr_picker.sv
// tft_arbiter_rr_picker: first requester found scanning last+1, last+2, ... modulo N
module tft_arbiter_rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 valid_o
);
    localparam int OW = $clog2(N);
    logic [OW-1:0] j;
    // Scanning from the farthest slot down lets the nearest requester win last
    always_comb begin
        idx_o = '0;
        j = '0;
        for (int k = N; k >= 1; k--) begin
            j = OW'((int'(last_i) + k) % N);
            if (req_i[j]) idx_o = j;
        end
    end
    assign valid_o = |req_i;
endmodule

// File: rtl/tft_arbiter.sv
// tft_arbiter: round-robin owner of the shared TFT byte link, one client draw pass per grant
module tft_arbiter
    import tft_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         cl_busy,
    input  logic [N-1:0]         cl_dc,
    input  logic [8*N-1:0]       cl_data,
    input  logic [N-1:0]         cl_transmit,
    output logic [N-1:0]         cl_enable,
    output logic [N-1:0]         cl_tft_busy,
    input  logic                 tft_busy,
    output logic                 tft_dc,
    output logic [7:0]           tft_data,
    output logic                 tft_transmit,
    output logic [$clog2(N)-1:0] owner,
    output logic                 timeout_err
);
    localparam int OW = $clog2(N);
    localparam int CW = $clog2(START_TIMEOUT) + 1;

    arb_state_e    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, pick;
    logic [N-1:0]  grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          terr_q, terr_d, pick_valid, own_busy, granted;

    tft_arbiter_rr_picker #(.N(N)) u_pick (
        .req_i  (req),
        .last_i (owner_q),
        .idx_o  (pick),
        .valid_o(pick_valid)
    );

    assign own_busy    = cl_busy[owner_q];
    assign granted     = |grant_q;
    // Enable drops the same cycle busy falls so the client cannot start a second pass
    assign cl_enable   = (state_q == DRAW) ? (grant_q & {N{own_busy}}) : grant_q;
    assign cl_tft_busy = ~grant_q | {N{tft_busy}};
    assign tft_dc      = granted & cl_dc[owner_q];
    assign tft_data    = granted ? cl_data[{owner_q, 3'b000} +: 8] : 8'h00;
    // The owner's final strobe may still be high in the first draining cycle
    assign tft_transmit = (granted || state_q == DRAIN) && cl_transmit[owner_q];
    assign owner       = owner_q;
    assign timeout_err = terr_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        unique case (state_q)
            IDLE: if (pick_valid) begin
                owner_d = pick;
                grant_d = N'(1) << pick;
                cnt_d   = '0;
                state_d = START;
            end
            START: if (own_busy) begin
                state_d = DRAW;
            end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                grant_d = '0;
                terr_d  = 1'b1;
                state_d = DRAIN;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            DRAW: if (!own_busy) begin
                grant_d = '0;
                state_d = DRAIN;
            end
            DRAIN: if (!tft_busy && !tft_transmit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OW'(N - 1);
            grant_q <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end
endmodule

// File: tb/tb_tft_arbiter.sv
// tb_tft_arbiter: directed and random stimulus checked every cycle against a behavioural arbiter model
module tb_tft_arbiter;
    localparam int N = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0, cl_busy = '0, cl_dc = '0, cl_transmit = '0;
    logic [8*N-1:0] cl_data = '0;
    logic tft_busy = 1'b0;
    logic [N-1:0] cl_enable, cl_tft_busy;
    logic tft_dc, tft_transmit, timeout_err;
    logic [7:0] tft_data;
    logic [1:0] owner;

    tft_arbiter #(.N(N), .START_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .cl_busy(cl_busy), .cl_dc(cl_dc),
        .cl_data(cl_data), .cl_transmit(cl_transmit), .cl_enable(cl_enable),
        .cl_tft_busy(cl_tft_busy), .tft_busy(tft_busy), .tft_dc(tft_dc),
        .tft_data(tft_data), .tft_transmit(tft_transmit), .owner(owner),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    // Model: who holds the link and in which phase of its pass
    int m_owner = N - 1, m_wait = 0;
    bit m_granted = 0, m_started = 0, m_draining = 0, m_terr = 0;
    // Environment: well-behaved clients plus a serializer that stays busy tft_len cycles per byte
    bit env_on = 1, iso = 0;
    logic [N-1:0] want = '0, mute = '0, noise = '0;
    int npass [N];
    int left [N];
    int tft_len = 3, tcnt = 0, bytes = 0, iso_bad = 0, last_fall = 0;
    logic s_tx = 1'b0, prev_tb = 1'b0;
    logic [N-1:0] s_en = '0, s_ctb = '0;
    int rises[$], rise_cyc[$], terr_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] e_en();
        if (!m_granted || (m_started && !cl_busy[m_owner])) return '0;
        return N'(1) << m_owner;
    endfunction

    function automatic logic e_tx();
        return (m_granted || m_draining) && cl_transmit[m_owner];
    endfunction

    function automatic logic [N-1:0] e_ctb();
        logic [N-1:0] v = '1;
        if (m_granted) v[m_owner] = tft_busy;
        return v;
    endfunction

    task automatic model_update();
        logic etx = e_tx();
        m_terr = 0;
        if (rst) begin
            m_owner = N - 1; m_granted = 0; m_started = 0; m_draining = 0; m_wait = 0;
        end else if (m_draining) begin
            if (!tft_busy && !etx) m_draining = 0;
        end else if (m_granted && !m_started) begin
            if (cl_busy[m_owner]) m_started = 1;
            else if (m_wait == TO - 1) begin m_granted = 0; m_terr = 1; m_draining = 1; end
            else m_wait++;
        end else if (m_granted) begin
            if (!cl_busy[m_owner]) begin m_granted = 0; m_started = 0; m_draining = 1; end
        end else begin
            for (int k = 1; k <= N && !m_granted; k++)
                if (req[(m_owner + k) % N]) begin
                    m_owner = (m_owner + k) % N; m_granted = 1; m_started = 0; m_wait = 0;
                end
        end
    endtask

    task automatic compare();
        chk("cl_enable", 32'(cl_enable), 32'(e_en()));
        chk("cl_tft_busy", 32'(cl_tft_busy), 32'(e_ctb()));
        chk("tft_dc", 32'(tft_dc), 32'(m_granted && cl_dc[m_owner]));
        chk("tft_data", 32'(tft_data), m_granted ? 32'(cl_data[8*m_owner +: 8]) : 32'd0);
        chk("tft_transmit", 32'(tft_transmit), 32'(e_tx()));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("onehot", 32'($countones(cl_enable) <= 1), 32'd1);
        if (cl_enable != '0 && s_en == '0) begin
            for (int i = 0; i < N; i++) if (cl_enable[i]) begin rises.push_back(i); break; end
            rise_cyc.push_back(cyc);
        end
        if (prev_tb && !tft_busy) last_fall = cyc;
        if (timeout_err) terr_cyc.push_back(cyc);
        if (tft_transmit) bytes++;
        if (iso && (cl_tft_busy[2] !== 1'b1 || (tft_transmit && !cl_transmit[1]))) iso_bad++;
        prev_tb = tft_busy; s_tx = tft_transmit; s_en = cl_enable; s_ctb = cl_tft_busy;
    endtask

    task automatic env();
        if (s_tx) tcnt = tft_len;
        else if (tcnt > 0) tcnt--;
        tft_busy = (tcnt > 0);
        for (int i = 0; i < N; i++) begin
            logic sent = cl_transmit[i];
            cl_transmit[i] = 1'b0;
            req[i] = want[i];
            if (rst) begin
                cl_busy[i] = 1'b0; left[i] = 0;
            end else if (!cl_busy[i]) begin
                if (s_en[i] && !mute[i]) begin cl_busy[i] = 1'b1; left[i] = npass[i]; end
                else if (noise[i] && $urandom_range(0, 2) == 0) begin
                    cl_transmit[i] = 1'b1; cl_data[8*i +: 8] = 8'($urandom);
                end
            end else if (left[i] == 0) begin
                cl_busy[i] = 1'b0;
            end else if (!s_ctb[i] && !sent) begin
                cl_transmit[i] = 1'b1; cl_dc[i] = 1'($urandom); cl_data[8*i +: 8] = 8'($urandom);
                left[i]--;
                if (left[i] == 0) cl_busy[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
        if (env_on) env();
    endtask

    task automatic set_want(input logic [N-1:0] v);
        want = v; req = v;
    endtask

    task automatic do_reset();
        rst = 1'b1; mute = '0; noise = '0; iso = 0;
        set_want('0);
        repeat (2) step();
        rst = 1'b0;
        rises.delete(); rise_cyc.delete(); terr_cyc.delete(); bytes = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin npass[i] = 5; left[i] = 0; end
        repeat (2) step();
        chk("reset_enable", 32'(cl_enable), 32'd0);
        chk("reset_owner", 32'(owner), 32'd3);
        chk("reset_timeout_err", 32'(timeout_err), 32'd0);
        chk("reset_transmit", 32'(tft_transmit), 32'd0);
        rst = 1'b0;

        // single client, 11-byte pass
        tft_len = 3; npass[0] = 11; bytes = 0;
        set_want(4'b0001);
        step();
        chk("single_grant_latency", 32'(cl_enable), 32'h1);
        set_want('0);
        repeat (200) step();
        chk("single_bytes", bytes, 11);
        chk("single_owner", 32'(owner), 32'd0);

        // fairness with every client requesting
        do_reset();
        tft_len = 2;
        for (int i = 0; i < N; i++) npass[i] = 5;
        set_want(4'b1111);
        for (int k = 0; k < 2000 && rises.size() < 5; k++) step();
        chk("fair_grants_seen", 32'(rises.size() >= 5), 32'd1);
        for (int j = 0; j < 5 && j < rises.size(); j++) chk("fair_order", rises[j], j % N);

        // isolation of a non-owner strobing while client 1 draws
        do_reset();
        tft_len = 2; npass[1] = 8; noise = 4'b0100; iso = 1;
        set_want(4'b0010);
        step();
        set_want('0);
        repeat (150) step();
        iso = 0;
        chk("iso_violations", iso_bad, 0);
        chk("iso_bytes", bytes, 8);

        // start timeout on a client that never raises busy
        do_reset();
        tft_len = 2; npass[0] = 3; mute = 4'b1000;
        set_want(4'b1000);
        for (int k = 0; k < 10 && rises.size() < 1; k++) step();
        chk("to_first_grant", 32'(rises.size() == 1 && rises[0] == 3), 32'd1);
        set_want(4'b1001);
        for (int k = 0; k < 40 && terr_cyc.size() < 1; k++) step();
        chk("to_pulse_seen", 32'(terr_cyc.size()), 32'd1);
        if (terr_cyc.size() > 0 && rise_cyc.size() > 0) chk("to_delay", terr_cyc[0] - rise_cyc[0], 16);
        for (int k = 0; k < 40 && rises.size() < 2; k++) step();
        chk("to_next_seen", 32'(rises.size() >= 2), 32'd1);
        if (rises.size() >= 2) chk("to_next_client", rises[1], 0);

        // drain waits for a long final byte before the back-to-back regrant
        do_reset();
        tft_len = 20; npass[0] = 4;
        set_want(4'b0001);
        for (int k = 0; k < 800 && rises.size() < 2; k++) step();
        chk("drain_regrant_seen", 32'(rises.size() >= 2), 32'd1);
        if (rises.size() >= 2) chk("drain_gap", rise_cyc[1] - last_fall, 2);

        // reset in the middle of client 2's pass
        do_reset();
        tft_len = 1; npass[2] = 10;
        set_want(4'b0100);
        for (int k = 0; k < 300 && bytes < 5; k++) step();
        chk("rst_bytes_reached", bytes, 5);
        rst = 1'b1;
        step();
        chk("rst_enable", 32'(cl_enable), 32'd0);
        chk("rst_transmit", 32'(tft_transmit), 32'd0);
        chk("rst_owner", 32'(owner), 32'd3);
        rst = 1'b0;
        rises.delete(); rise_cyc.delete();
        set_want(4'b0101);
        for (int k = 0; k < 20 && rises.size() < 1; k++) step();
        chk("rst_regrant_seen", 32'(rises.size()), 32'd1);
        if (rises.size() > 0) chk("rst_first_client", rises[0], 0);

        // unconstrained random inputs
        do_reset();
        env_on = 0;
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 9) == 0) cl_busy[i] = ~cl_busy[i];
                cl_data[8*i +: 8] = 8'($urandom);
            end
            cl_dc = N'($urandom);
            cl_transmit = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 2) == 0) tft_busy = ~tft_busy;
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
